// File: rtl/pmem_line_responder_pkg.sv
// Shared types for the cache <-> physical-memory line interface.
package pmem_line_responder_pkg;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;

  localparam int unsigned LC3B_LINE_OFFSET_BITS = 4;

  typedef enum logic [1:0] {
    pmem_idle,
    pmem_busy,
    pmem_resp
  } lc3b_pmem_state;

endpackage

// File: rtl/pmem_line_array.sv
// Line-addressed backing store: one synchronous write port, one combinational read port.
// Contents are intentionally not reset.
module pmem_line_array #(
  parameter int unsigned DEPTH_LINES = 32
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [$clog2(DEPTH_LINES)-1:0] waddr,
  input  logic [127:0]                   wdata,
  input  logic [$clog2(DEPTH_LINES)-1:0] raddr,
  output logic [127:0]                   rdata
);
  import pmem_line_responder_pkg::*;

  lc3b_line mem_q [DEPTH_LINES];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/pmem_line_responder.sv
// Fixed-latency responder for 128-bit line read/write requests from the L1 cache.
// Optional PMEM_STATS_EN adds rd_count/wr_count completion counters.
module pmem_line_responder #(
  parameter int unsigned LATENCY     = 4,
  parameter int unsigned DEPTH_LINES = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [15:0]  pmem_address,
  input  logic [127:0] pmem_wdata,
  output logic [127:0] pmem_rdata,
  output logic         pmem_resp,
  output logic         pmem_busy
`ifdef PMEM_STATS_EN
  ,
  output logic [15:0]  rd_count,
  output logic [15:0]  wr_count
`endif
);
  import pmem_line_responder_pkg::*;

  localparam int unsigned IDX_W = $clog2(DEPTH_LINES);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  // Port names shadow the enum literals, so the states are reached through aliases.
  localparam lc3b_pmem_state S_IDLE = pmem_line_responder_pkg::pmem_idle;
  localparam lc3b_pmem_state S_BUSY = pmem_line_responder_pkg::pmem_busy;
  localparam lc3b_pmem_state S_RESP = pmem_line_responder_pkg::pmem_resp;

  lc3b_pmem_state   state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             is_write_q, is_write_d;
  lc3b_line         wdata_q, wdata_d;
  lc3b_line         arr_rdata;
  logic             in_resp;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^pmem_address;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      is_write_q <= 1'b0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      is_write_q <= is_write_d;
      wdata_q    <= wdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    is_write_d = is_write_q;
    wdata_d    = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (pmem_read || pmem_write) begin
          // Write wins when both strobes are high.
          idx_d      = pmem_address[LC3B_LINE_OFFSET_BITS +: IDX_W];
          is_write_d = pmem_write;
          wdata_d    = pmem_wdata;
          cnt_d      = CNT_INIT;
          state_d    = (LATENCY == 1) ? S_RESP : S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign in_resp    = (state_q == S_RESP);
  assign pmem_resp  = in_resp;
  assign pmem_busy  = (state_q != S_IDLE);
  assign pmem_rdata = (in_resp && !is_write_q) ? arr_rdata : '0;

  pmem_line_array #(
    .DEPTH_LINES(DEPTH_LINES)
  ) u_array (
    .clk  (clk),
    .we   (in_resp && is_write_q),
    .waddr(idx_q),
    .wdata(wdata_q),
    .raddr(idx_q),
    .rdata(arr_rdata)
  );

`ifdef PMEM_STATS_EN
  logic [15:0] rd_count_q, rd_count_d;
  logic [15:0] wr_count_q, wr_count_d;

  always_comb begin
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    if (in_resp) begin
      if (is_write_q) begin
        wr_count_d = wr_count_q + 16'd1;
      end else begin
        rd_count_d = rd_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_pmem_line_responder.sv
// Randomized bench for pmem_line_responder against a line-array reference model.
// Two instances: LATENCY=4/32 lines and LATENCY=1/8 lines.
module tb_pmem_line_responder;

  localparam int unsigned LAT_A   = 4;
  localparam int unsigned DEPTH_A = 32;
  localparam int unsigned LAT_B   = 1;
  localparam int unsigned DEPTH_B = 8;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic         a_rd, a_wr, a_resp, a_busy;
  logic [15:0]  a_addr;
  logic [127:0] a_wdata, a_rdata;
  logic         b_rd, b_wr, b_resp, b_busy;
  logic [15:0]  b_addr;
  logic [127:0] b_wdata, b_rdata;
`ifdef PMEM_STATS_EN
  logic [15:0]  a_rdc, a_wrc, b_rdc, b_wrc;
`endif

  pmem_line_responder #(.LATENCY(LAT_A), .DEPTH_LINES(DEPTH_A)) dut_a (
    .clk(clk), .reset_n(reset_n), .pmem_read(a_rd), .pmem_write(a_wr),
    .pmem_address(a_addr), .pmem_wdata(a_wdata), .pmem_rdata(a_rdata),
    .pmem_resp(a_resp), .pmem_busy(a_busy)
`ifdef PMEM_STATS_EN
    , .rd_count(a_rdc), .wr_count(a_wrc)
`endif
  );

  pmem_line_responder #(.LATENCY(LAT_B), .DEPTH_LINES(DEPTH_B)) dut_b (
    .clk(clk), .reset_n(reset_n), .pmem_read(b_rd), .pmem_write(b_wr),
    .pmem_address(b_addr), .pmem_wdata(b_wdata), .pmem_rdata(b_rdata),
    .pmem_resp(b_resp), .pmem_busy(b_busy)
`ifdef PMEM_STATS_EN
    , .rd_count(b_rdc), .wr_count(b_wrc)
`endif
  );

  int unsigned  n_checks = 0;
  int unsigned  n_fail   = 0;
  logic [127:0] mem [2][256];
  logic [15:0]  exp_rd [2];
  logic [15:0]  exp_wr [2];
  time          last_resp_t;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [127:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int unsigned line_of(input int sel, input logic [15:0] addr);
    int unsigned depth = (sel == 0) ? DEPTH_A : DEPTH_B;
    return (int'(addr) / 16) % depth;
  endfunction

  // Edges from the sampling edge until the RESP cycle; LATENCY=1 goes straight to RESP.
  function automatic int unsigned resp_edges(input int sel);
    int unsigned lat = (sel == 0) ? LAT_A : LAT_B;
    return (lat == 1) ? 0 : lat;
  endfunction

  function automatic logic obs_resp(input int sel);
    return (sel == 0) ? a_resp : b_resp;
  endfunction
  function automatic logic obs_busy(input int sel);
    return (sel == 0) ? a_busy : b_busy;
  endfunction
  function automatic logic [127:0] obs_rdata(input int sel);
    return (sel == 0) ? a_rdata : b_rdata;
  endfunction

  task automatic check_stats(input string when);
`ifdef PMEM_STATS_EN
    chk({when, "_a_rd_count"}, a_rdc, exp_rd[0]);
    chk({when, "_a_wr_count"}, a_wrc, exp_wr[0]);
    chk({when, "_b_rd_count"}, b_rdc, exp_rd[1]);
    chk({when, "_b_wr_count"}, b_wrc, exp_wr[1]);
`endif
  endtask

  task automatic drive(input int sel, input logic rd, input logic wr,
                       input logic [15:0] addr, input logic [127:0] wd);
    if (sel == 0) begin
      a_rd = rd; a_wr = wr; a_addr = addr; a_wdata = wd;
    end else begin
      b_rd = rd; b_wr = wr; b_addr = addr; b_wdata = wd;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
  endtask

  // One transaction; request stays held through RESP. b2b leaves it up for the next call.
  task automatic txn(input int sel, input logic rd, input logic wr,
                     input logic [15:0] addr, input logic [127:0] wd, input bit b2b);
    int unsigned  line = line_of(sel, addr);
    logic [127:0] expd = wr ? 128'h0 : mem[sel][line];
    int unsigned  cyc = 0;
    @(negedge clk);
    drive(sel, rd, wr, addr, wd);
    @(posedge clk);
    #1;
    while (!obs_resp(sel) && cyc < 40) begin
      chk("busy_wait", obs_busy(sel), 1'b1);
      chk("rdata_quiet", obs_rdata(sel), 128'h0);
      @(posedge clk);
      #1;
      cyc++;
    end
    last_resp_t = $time;
    chk("resp_latency", cyc, resp_edges(sel));
    chk("busy_in_resp", obs_busy(sel), 1'b1);
    if (wr) chk("write_rdata_zero", obs_rdata(sel), expd);
    else    chk("read_data", obs_rdata(sel), expd);
    if (wr) begin
      mem[sel][line] = wd;
      exp_wr[sel]++;
    end else begin
      exp_rd[sel]++;
    end
    @(posedge clk);
    #1;
    chk("resp_one_cycle", obs_resp(sel), 1'b0);
    chk("no_reaccept", obs_busy(sel), 1'b0);
    chk("rdata_after_resp", obs_rdata(sel), 128'h0);
    check_stats("txn");
    if (!b2b) idle();
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] big;
    time          t0;
    reset_n = 1'b0;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    for (int s = 0; s < 2; s++) begin
      exp_rd[s] = '0;
      exp_wr[s] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_resp", a_resp, 1'b0);
    chk("rst_a_busy", a_busy, 1'b0);
    chk("rst_a_rdata", a_rdata, 128'h0);
    chk("rst_b_resp", b_resp, 1'b0);
    chk("rst_b_busy", b_busy, 1'b0);
    check_stats("rst");
    @(negedge clk);
    reset_n = 1'b1;

    // Preload every line so later reads have defined expectations.
    for (int unsigned i = 0; i < DEPTH_A; i++) txn(0, 1'b0, 1'b1, 16'(i * 16), rand_line(), 1'b0);
    for (int unsigned i = 0; i < DEPTH_B; i++) txn(1, 1'b0, 1'b1, 16'(i * 16), rand_line(), 1'b0);

    big = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
    txn(0, 1'b0, 1'b1, 16'h0040, big, 1'b0);
    txn(0, 1'b1, 1'b0, 16'h0040, '0, 1'b0);
    txn(0, 1'b1, 1'b0, 16'h004F, '0, 1'b0);
    txn(0, 1'b1, 1'b0, 16'h0440, '0, 1'b0);

    txn(0, 1'b1, 1'b1, 16'h0020, 128'h1, 1'b0);
    txn(0, 1'b1, 1'b0, 16'h0020, '0, 1'b0);

    // Reset two cycles into a write: no commit, outputs drop asynchronously.
    txn(0, 1'b0, 1'b1, 16'h0060, 128'h5, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 16'h0060, 128'hABCD_EF01);
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort_busy", a_busy, 1'b0);
    chk("abort_resp", a_resp, 1'b0);
    chk("abort_rdata", a_rdata, 128'h0);
    drive(0, 1'b0, 1'b0, '0, '0);
    for (int s = 0; s < 2; s++) begin
      exp_rd[s] = '0;
      exp_wr[s] = '0;
    end
    check_stats("abort");
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("abort_no_resp", a_resp, 1'b0);
    end
    txn(0, 1'b1, 1'b0, 16'h0060, '0, 1'b0);

    // LATENCY=1 back-to-back reads: one RESP every two cycles.
    txn(1, 1'b1, 1'b0, 16'h0010, '0, 1'b1);
    t0 = last_resp_t;
    txn(1, 1'b1, 1'b0, 16'h0020, '0, 1'b1);
    chk("b2b_period_1", last_resp_t - t0, 20);
    t0 = last_resp_t;
    txn(1, 1'b1, 1'b0, 16'h0030, '0, 1'b0);
    chk("b2b_period_2", last_resp_t - t0, 20);

    txn(1, 1'b0, 1'b1, 16'h0050, rand_line(), 1'b0);
    txn(1, 1'b0, 1'b1, 16'h0060, rand_line(), 1'b0);

    for (int n = 0; n < 80; n++) begin
      int          sel = int'($urandom_range(0, 1));
      int unsigned op  = $urandom_range(0, 4);
      logic        rd  = (op <= 1) || (op == 4);
      logic        wr  = (op == 2) || (op == 3) || (op == 4);
      txn(sel, rd, wr, 16'($urandom), rand_line(), 1'b0);
    end

    idle();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
